multicast_fork_ctrl: RTL and testbench
======================================

// Module: multicast_fork_ctrl
// PURPOSE
//  Replication sequencer for one multicast input (Nm or Wm) of the switch allocator.
//  Latches the head flit and its 3-bit branch mask {E,S,L}, then requests each output
//  arbiter and holds the flit until every branch has been granted and accepted.
//  Pops the upstream multicast buffer once the last branch is served. Replaces the
//  per-label ready logic for multicast inputs with an explicit per-branch pending state.
// PARAMETERS
//  DATASIZE  30  flit width in bits
//  MAX_WAIT  15  SERVE cycles with no branch served before starve is raised (>=1)
//  CNT_W     4   wait-counter width; must satisfy 2**CNT_W-1 >= MAX_WAIT
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         reset, asynchronous, active-high (reset while rst_n==1)
//  flush      in   1         synchronous abort: drop held flit, return to IDLE
//  in_valid   in   1         upstream multicast buffer has a head flit
//  in_data    in   DATASIZE  head flit
//  in_label   in   3         branch mask {E,S,L} for head flit
//  in_ready   out  1         pop strobe to upstream buffer (combinational)
//  req        out  3         per-branch request {E,S,L} to output RR arbiters
//  grant      in   3         per-branch grant {E,S,L} from output RR arbiters
//  e_full     in   1         East downstream full
//  s_full     in   1         South downstream full
//  out_valid  out  3         per-branch transfer strobe {E,S,L}
//  out_data   out  DATASIZE  held flit, driven to all branch muxes
//  busy       out  1         1 while in SERVE
//  starve     out  1         wait counter reached MAX_WAIT
// BEHAVIOUR
//  Reset: state=IDLE, pending=3'b000, data_q=0, wait_cnt=0; thus req=0, out_valid=0,
//   out_data=0, in_ready=0, busy=0, starve=0. Reset mid-SERVE discards flit, no pop.
//  served[b] = req[b] & grant[b] & ~full[b], with full = {e_full, s_full, 1'b0} (L never full).
//  IDLE: req=0. If in_valid & in_label!=0: data_q<=in_data, pending<=in_label, -> SERVE.
//   If in_valid & in_label==0: in_ready=1 (drop empty-mask flit), stay IDLE.
//  SERVE: req=pending; out_valid=served; out_data=data_q; pending<=pending&~served.
//   in_ready=1 in the cycle (pending&~served)==0; next state IDLE.
//   Simultaneous grants on several branches serve all of them in the same cycle.
//   Grant on a branch with full asserted: not served, bit stays pending, req stays high.
//   Grant on a branch not in req: ignored.
//  Latency: flit latched at edge N; earliest out_valid and in_ready in cycle N+1;
//   back-to-back flits: next flit latched one cycle after pop (1 idle cycle minimum).
//  wait_cnt: in SERVE, cleared on any served bit, else +1 saturating at MAX_WAIT;
//   cleared in IDLE. starve = (wait_cnt==MAX_WAIT); informational only, no state change.
//  flush (priority over all but reset): next state IDLE, pending=0, wait_cnt=0; no pop,
//   out_valid=0 and in_ready=0 in the flush cycle.
//  in_data/in_label sampled only on IDLE->SERVE; changes while in SERVE are ignored.
// TESTING
//  1 label=3'b111, data=30'h1234, grant=3'b111 cycle1, fulls 0 -> out_valid=111 cycle1,
//    in_ready=1 cycle1, busy=0 cycle2.
//  2 label=3'b101, grant E cycle1, grant L cycle3 -> out_valid=100 c1, 001 c3; req=001 c2-c3;
//    in_ready only c3.
//  3 label=3'b010, grant S c1-c3 with s_full=1 c1-c2 -> out_valid=000 c1-c2, 010 c3,
//    wait_cnt 1,2 then 0.
//  4 label=3'b100, no grant 20 cycles, MAX_WAIT=15 -> starve=1 from c16, held, no pop;
//    then flush -> IDLE, req=0, in_ready stays 0.
//  5 in_valid=1, label=000 in IDLE -> in_ready=1 same cycle, req=0, busy=0.
//  6 rst_n=1 pulsed mid-SERVE with pending=011 -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/multicast_fork_ctrl_if.sv
// Handshake bundle between a multicast input buffer, the output
// arbiters and the multicast replication sequencer.
interface multicast_fork_ctrl_if #(
    parameter int DATASIZE = 30
);
    logic                in_valid;
    logic [DATASIZE-1:0] in_data;
    logic [2:0]          in_label;
    logic                in_ready;
    logic [2:0]          req;
    logic [2:0]          grant;
    logic                e_full;
    logic                s_full;
    logic [2:0]          out_valid;
    logic [DATASIZE-1:0] out_data;
    logic                busy;
    logic                starve;

    modport slave (
        input  in_valid, in_data, in_label, grant, e_full, s_full,
        output in_ready, req, out_valid, out_data, busy, starve
    );

    modport master (
        output in_valid, in_data, in_label, grant, e_full, s_full,
        input  in_ready, req, out_valid, out_data, busy, starve
    );
endinterface

// File: rtl/multicast_fork_ctrl.sv
// Multicast replication sequencer: holds one head flit and requests
// each branch {E,S,L} of its mask until all branches are served.
module multicast_fork_ctrl #(
    parameter int DATASIZE = 30,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    multicast_fork_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          pending_q, pending_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [2:0] full_v;
    logic [2:0] served;
    logic [2:0] req_c;
    logic       pop_c;

    assign full_v = {bus.e_full, bus.s_full, 1'b0};

    // Next state, pending mask, hold register and wait counter.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        data_d     = data_q;
        wait_cnt_d = wait_cnt_q;
        req_c      = 3'b000;
        served     = 3'b000;
        pop_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (bus.in_valid) begin
                    if (bus.in_label != 3'b000) begin
                        data_d    = bus.in_data;
                        pending_d = bus.in_label;
                        state_d   = SERVE;
                    end else begin
                        // Empty mask: nothing to replicate, just pop it.
                        pop_c = 1'b1;
                    end
                end
            end
            SERVE: begin
                req_c     = pending_q;
                served    = req_c & bus.grant & ~full_v;
                pending_d = pending_q & ~served;
                if (served != 3'b000) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                if (pending_d == 3'b000) begin
                    pop_c   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        // Abort drops the held flit without popping or transferring.
        if (flush) begin
            state_d    = IDLE;
            pending_d  = 3'b000;
            wait_cnt_d = '0;
            req_c      = 3'b000;
            served     = 3'b000;
            pop_c      = 1'b0;
        end
    end

    // State registers; reset is asserted while rst_n is high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 3'b000;
            data_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.req       = req_c;
    assign bus.out_valid = served;
    assign bus.out_data  = data_q;
    assign bus.in_ready  = pop_c & ~rst_n;
    assign bus.busy      = (state_q == SERVE);
    assign bus.starve    = (wait_cnt_q == CNT_W'(MAX_WAIT));
endmodule

// File: tb/tb_multicast_fork_ctrl.sv
// Self-checking bench: per-cycle vector table plus a flit
// scoreboard that tracks which branches each held flit still owes.
module tb_multicast_fork_ctrl;
    localparam int DW = 30;

    logic clk;
    logic rst_n;
    logic flush;

    multicast_fork_ctrl_if #(.DATASIZE(DW)) bus ();

    multicast_fork_ctrl #(
        .DATASIZE(DW),
        .MAX_WAIT(15),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [2:0]    lbl;
        logic [DW-1:0] dat;
        logic [2:0]    gnt;
        logic          ef;
        logic          sf;
        logic          fl;
        logic [2:0]    e_req;
        logic          chk_req;
        logic [2:0]    e_ov;
        logic          e_ir;
        logic          e_busy;
        logic          e_st;
    } vec_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [2:0]    mask;
    } flit_t;

    vec_t  tbl[$];
    flit_t sbq[$];
    bit    sb_idle;
    int    n_pass;
    int    n_total;

    function automatic vec_t mk(
        logic iv, logic [2:0] lbl, logic [DW-1:0] dat,
        logic [2:0] gnt, logic ef, logic sf, logic fl,
        logic [2:0] e_req, logic chk_req, logic [2:0] e_ov,
        logic e_ir, logic e_busy, logic e_st
    );
        vec_t v;
        v.iv = iv; v.lbl = lbl; v.dat = dat; v.gnt = gnt;
        v.ef = ef; v.sf = sf; v.fl = fl;
        v.e_req = e_req; v.chk_req = chk_req; v.e_ov = e_ov;
        v.e_ir = e_ir; v.e_busy = e_busy; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Compares observed branch transfers against the owed mask.
    task automatic sb_check();
        if (bus.out_valid != 3'b000) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_xfer", {29'd0, bus.out_valid}, 32'd0);
            end else begin
                chk("sb_out_data", 32'(bus.out_data), 32'(sbq[0].dat));
                chk("sb_branch_owed",
                    {29'd0, bus.out_valid & ~sbq[0].mask}, 32'd0);
                sbq[0].mask = sbq[0].mask & ~bus.out_valid;
                if (sbq[0].mask == 3'b000) begin
                    chk("sb_pop_on_last", {31'd0, bus.in_ready}, 32'd1);
                    void'(sbq.pop_front());
                    sb_idle = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(vec_t v);
        bus.in_valid = v.iv;
        bus.in_label = v.lbl;
        bus.in_data  = v.dat;
        bus.grant    = v.gnt;
        bus.e_full   = v.ef;
        bus.s_full   = v.sf;
        flush        = v.fl;
        if (v.fl) begin
            sbq.delete();
            sb_idle = 1'b1;
        end else if (sb_idle && v.iv && v.lbl != 3'b000) begin
            flit_t f;
            f.dat  = v.dat;
            f.mask = v.lbl;
            sbq.push_back(f);
            sb_idle = 1'b0;
        end
    endtask

    task automatic run_row(vec_t v, int idx);
        drive(v);
        @(negedge clk);
        if (v.chk_req)
            chk($sformatf("req[%0d]", idx), {29'd0, bus.req}, {29'd0, v.e_req});
        chk($sformatf("out_valid[%0d]", idx),
            {29'd0, bus.out_valid}, {29'd0, v.e_ov});
        chk($sformatf("in_ready[%0d]", idx),
            {31'd0, bus.in_ready}, {31'd0, v.e_ir});
        chk($sformatf("busy[%0d]", idx),
            {31'd0, bus.busy}, {31'd0, v.e_busy});
        chk($sformatf("starve[%0d]", idx),
            {31'd0, bus.starve}, {31'd0, v.e_st});
        sb_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        sb_idle = 1'b1;
        rst_n   = 1'b1;
        flush   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_label = 3'b000;
        bus.in_data  = '0;
        bus.grant    = 3'b111;
        bus.e_full   = 1'b0;
        bus.s_full   = 1'b0;

        // Reset state with an empty-mask flit offered: no pop allowed.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {29'd0, bus.req}, 32'd0);
        chk("rst_out_valid", {29'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_starve", {31'd0, bus.starve}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // All three branches granted in the first SERVE cycle.
        tbl.push_back(mk(1, 3'b111, 30'h1234, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b111, 30'h1234, 3'b111, 0, 0, 0, 3'b111, 1, 3'b111, 1, 1, 0));
        // Back-to-back: next flit latched in the idle cycle after the pop.
        tbl.push_back(mk(1, 3'b101, 30'h2AAAA, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b101, 30'h2AAAA, 3'b100, 0, 0, 0, 3'b101, 1, 3'b100, 0, 1, 0));
        tbl.push_back(mk(1, 3'b101, 30'h2AAAA, 3'b110, 0, 0, 0, 3'b001, 1, 3'b000, 0, 1, 0));
        tbl.push_back(mk(1, 3'b101, 30'h2AAAA, 3'b001, 0, 0, 0, 3'b001, 1, 3'b001, 1, 1, 0));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // South full blocks the grant; input changes during SERVE ignored.
        tbl.push_back(mk(1, 3'b010, 30'h3C0FFEE, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b111, 30'h15, 3'b010, 0, 1, 0, 3'b010, 1, 3'b000, 0, 1, 0));
        tbl.push_back(mk(1, 3'b111, 30'h15, 3'b010, 0, 1, 0, 3'b010, 1, 3'b000, 0, 1, 0));
        tbl.push_back(mk(1, 3'b010, 30'h3C0FFEE, 3'b010, 0, 0, 0, 3'b010, 1, 3'b010, 1, 1, 0));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // Empty-mask flit dropped in IDLE.
        tbl.push_back(mk(1, 3'b000, 30'h5, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 1, 0, 0));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // East full: S served now, E later.
        tbl.push_back(mk(1, 3'b110, 30'hBEEF, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b110, 30'hBEEF, 3'b110, 1, 0, 0, 3'b110, 1, 3'b010, 0, 1, 0));
        tbl.push_back(mk(1, 3'b110, 30'hBEEF, 3'b110, 0, 0, 0, 3'b100, 1, 3'b100, 1, 1, 0));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // Starvation: no grant for 20 cycles, starve from cycle 16.
        tbl.push_back(mk(1, 3'b100, 30'h44, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        for (int k = 1; k <= 20; k++)
            tbl.push_back(mk(1, 3'b100, 30'h44, 3'b000, 0, 0, 0,
                             3'b100, 1, 3'b000, 0, 1, logic'(k >= 16)));
        // Flush beats a grant: no transfer, no pop.
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b100, 0, 0, 1, 3'b000, 0, 3'b000, 0, 1, 1));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // Flush in IDLE suppresses the empty-mask pop.
        tbl.push_back(mk(1, 3'b000, 30'h0, 3'b000, 0, 0, 1, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        // Flit for the reset-abort sequence: pending 011 after one cycle.
        tbl.push_back(mk(1, 3'b011, 30'h77, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b011, 30'h77, 3'b000, 0, 0, 0, 3'b011, 1, 3'b000, 0, 1, 0));

        foreach (tbl[i]) run_row(tbl[i], i);

        // Asynchronous reset mid-SERVE with grants present.
        bus.in_valid = 1'b0;
        bus.grant    = 3'b011;
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_rst_req", {29'd0, bus.req}, 32'd0);
        chk("async_rst_out_valid", {29'd0, bus.out_valid}, 32'd0);
        chk("async_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_starve", {31'd0, bus.starve}, 32'd0);
        sbq.delete();
        sb_idle = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Recovery after reset release.
        run_row(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0), 100);
        run_row(mk(1, 3'b001, 30'h99, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0), 101);
        run_row(mk(1, 3'b001, 30'h99, 3'b001, 0, 0, 0, 3'b001, 1, 3'b001, 1, 1, 0), 102);
        run_row(mk(0, 3'b000, 30'h0, 3'b000, 0, 0, 0, 3'b000, 1, 3'b000, 0, 0, 0), 103);

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
